// File: rtl/encoder_pkg.sv
// Shared types for the quadrature encoder front end: {A,B} state encoding and
// the transition decode used by the position counter.
package encoder_pkg;

  typedef enum logic [1:0] {
    QS_00 = 2'b00,
    QS_01 = 2'b01,
    QS_11 = 2'b11,
    QS_10 = 2'b10
  } quad_state_t;

  localparam quad_state_t QUAD_RESET_STATE = QS_11;

  typedef struct packed {
    logic              invalid;
    logic signed [1:0] delta;
  } quad_delta_t;

  // Position along the CW cycle 00->01->11->10, so a transition is a mod-4 difference.
  function automatic logic [1:0] quad_pos(quad_state_t s);
    case (s)
      QS_00:   return 2'd0;
      QS_01:   return 2'd1;
      QS_11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic quad_delta_t quad_delta(quad_state_t prev, quad_state_t cur);
    quad_delta_t r;
    logic [1:0]  d;
    r = '0;
    d = quad_pos(cur) - quad_pos(prev);
    case (d)
      2'd1:    r.delta = 2'sd1;
      2'd3:    r.delta = -2'sd1;
      2'd2:    r.invalid = 1'b1;
      default: r.delta = 2'sd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/quad_encoder_counter_if.sv
// Pin and display-side signals of the encoder counter, grouped so the
// counter and its driver share one bundle.
interface quad_encoder_counter_if;
  logic       i_encA;
  logic       i_encB;
  logic       i_encBtn;
  logic [7:0] o_count;
  logic [3:0] o_hexHigh;
  logic [3:0] o_hexLow;
  logic       o_step;
  logic       o_dir;

  modport master (
    output i_encA, i_encB, i_encBtn,
    input  o_count, o_hexHigh, o_hexLow, o_step, o_dir
  );

  modport slave (
    input  i_encA, i_encB, i_encBtn,
    output o_count, o_hexHigh, o_hexLow, o_step, o_dir
  );
endinterface

// File: rtl/debounce_filter.sv
// 2-FF synchroniser followed by a stability filter: the output follows the
// synchronised input only after P_DEBOUNCE consecutive differing cycles.
module debounce_filter #(
  parameter int   P_DEBOUNCE  = 50_000,
  parameter logic P_RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_stable
);

  localparam int            CW       = $clog2(P_DEBOUNCE);
  localparam logic [CW-1:0] CNT_LAST = CW'(P_DEBOUNCE - 1);

  logic [1:0]    sync_q, sync_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle matching the stable value restarts the run.
  always_comb begin
    sync_d   = {sync_q[0], i_raw};
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_LAST) stable_d = sync_q[1];
      else                   cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q   <= {2{P_RESET_VAL}};
      stable_q <= P_RESET_VAL;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_stable = stable_q;

endmodule

// File: rtl/quad_encoder_counter.sv
// Debounced quadrature decode into an 8-bit up/down position count with
// push-button clear; count is exported whole and as two hex nibbles.
module quad_encoder_counter
  import encoder_pkg::*;
#(
  parameter int P_DEBOUNCE = 50_000,
  parameter int P_DETENT   = 4,
  parameter int P_WRAP     = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  quad_encoder_counter_if.slave  bus
);

  localparam logic signed [3:0] DET_POS = 4'(P_DETENT);
  localparam logic signed [3:0] DET_NEG = -DET_POS;

  logic a_db, b_db, btn_db;

  debounce_filter #(.P_DEBOUNCE(P_DEBOUNCE), .P_RESET_VAL(1'b1)) u_db_a (
    .i_clk(i_clk), .i_rst(i_rst), .i_raw(bus.i_encA), .o_stable(a_db)
  );
  debounce_filter #(.P_DEBOUNCE(P_DEBOUNCE), .P_RESET_VAL(1'b1)) u_db_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_raw(bus.i_encB), .o_stable(b_db)
  );
  debounce_filter #(.P_DEBOUNCE(P_DEBOUNCE), .P_RESET_VAL(1'b0)) u_db_btn (
    .i_clk(i_clk), .i_rst(i_rst), .i_raw(bus.i_encBtn), .o_stable(btn_db)
  );

  quad_state_t       cur_qs, prev_q, prev_d;
  quad_delta_t       qd;
  logic signed [3:0] acc_q, acc_d, acc_sum;
  logic [7:0]        count_q, count_d;
  logic              step_q, step_d;
  logic              dir_q, dir_d;
  logic              btn_prev_q, btn_prev_d;

  always_comb begin
    cur_qs     = quad_state_t'({a_db, b_db});
    qd         = quad_delta(prev_q, cur_qs);
    acc_sum    = acc_q + {{2{qd.delta[1]}}, qd.delta};
    prev_d     = cur_qs;
    acc_d      = acc_sum;
    count_d    = count_q;
    step_d     = 1'b0;
    dir_d      = dir_q;
    btn_prev_d = btn_db;

    if (qd.invalid) begin
      acc_d = '0;
    end else if (acc_sum == DET_POS) begin
      acc_d = '0;
      dir_d = 1'b1;
      // A saturated step still records its direction but moves nothing.
      if (P_WRAP != 0 || count_q != 8'hFF) begin
        count_d = count_q + 8'd1;
        step_d  = 1'b1;
      end
    end else if (acc_sum == DET_NEG) begin
      acc_d = '0;
      dir_d = 1'b0;
      if (P_WRAP != 0 || count_q != 8'h00) begin
        count_d = count_q - 8'd1;
        step_d  = 1'b1;
      end
    end

    // Clear overrides any step completing in the same cycle, including its direction.
    if (btn_db && !btn_prev_q) begin
      count_d = '0;
      acc_d   = '0;
      step_d  = 1'b1;
      dir_d   = dir_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_q     <= QUAD_RESET_STATE;
      acc_q      <= '0;
      count_q    <= '0;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      btn_prev_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      btn_prev_q <= btn_prev_d;
    end
  end

  assign bus.o_count   = count_q;
  assign bus.o_hexHigh = count_q[7:4];
  assign bus.o_hexLow  = count_q[3:0];
  assign bus.o_step    = step_q;
  assign bus.o_dir     = dir_q;

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Directed bench: a wrapping and a saturating counter share the same pins;
// table vectors cover decode, plus hand sequences for timing/button/reset.
module tb_quad_encoder_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a   = 1'b1;
  logic b   = 1'b1;
  logic btn = 1'b0;

  always #5 clk = ~clk;

  quad_encoder_counter_if ifw ();
  quad_encoder_counter_if ifs ();

  assign ifw.i_encA   = a;
  assign ifw.i_encB   = b;
  assign ifw.i_encBtn = btn;
  assign ifs.i_encA   = a;
  assign ifs.i_encB   = b;
  assign ifs.i_encBtn = btn;

  quad_encoder_counter #(.P_DEBOUNCE(4), .P_DETENT(4), .P_WRAP(1)) dut (
    .i_clk(clk), .i_rst(rst), .bus(ifw)
  );
  quad_encoder_counter #(.P_DEBOUNCE(4), .P_DETENT(4), .P_WRAP(0)) dut_sat (
    .i_clk(clk), .i_rst(rst), .bus(ifs)
  );

  int nchk    = 0;
  int nerr    = 0;
  int nstep_w = 0;
  int nstep_s = 0;

  always @(negedge clk) begin
    if (ifw.o_step === 1'b1) nstep_w++;
    if (ifs.o_step === 1'b1) nstep_s++;
  end

  typedef struct {
    logic       a;
    logic       b;
    logic [7:0] cnt;
    logic       dir;
    int         steps;
    logic [7:0] scnt;
    int         ssteps;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic va, input logic vb, input logic [7:0] c, input logic d,
                     input int s, input logic [7:0] sc, input int ss);
    vec_t v;
    v.a = va; v.b = vb; v.cnt = c; v.dir = d; v.steps = s; v.scnt = sc; v.ssteps = ss;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic hold(input logic va, input logic vb, input int n);
    @(posedge clk); #1;
    a = va; b = vb;
    repeat (n) @(posedge clk);
    @(negedge clk); #1;
  endtask

  task automatic run_tbl(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      int s0, t0;
      s0 = nstep_w;
      t0 = nstep_s;
      hold(tbl[i].a, tbl[i].b, 10);
      chk($sformatf("vec%0d_count", i), ifw.o_count, tbl[i].cnt);
      chk($sformatf("vec%0d_hexhi", i), 8'(ifw.o_hexHigh), 8'(tbl[i].cnt[7:4]));
      chk($sformatf("vec%0d_hexlo", i), 8'(ifw.o_hexLow), 8'(tbl[i].cnt[3:0]));
      chk($sformatf("vec%0d_dir", i), 8'(ifw.o_dir), 8'(tbl[i].dir));
      chki($sformatf("vec%0d_steps", i), nstep_w - s0, tbl[i].steps);
      chk($sformatf("vec%0d_sat_count", i), ifs.o_count, tbl[i].scnt);
      chk($sformatf("vec%0d_sat_dir", i), 8'(ifs.o_dir), 8'(tbl[i].dir));
      chki($sformatf("vec%0d_sat_steps", i), nstep_s - t0, tbl[i].ssteps);
    end
  endtask

  // Expect the two counters to reach the given counts, directions and step deltas.
  task automatic chk_both(input string tag, input logic [7:0] c, input logic [7:0] sc,
                          input logic d, input int ds, input int dss);
    chk({tag, "_count"}, ifw.o_count, c);
    chk({tag, "_sat_count"}, ifs.o_count, sc);
    chk({tag, "_dir"}, 8'(ifw.o_dir), 8'(d));
    chk({tag, "_sat_dir"}, 8'(ifs.o_dir), 8'(d));
    chki({tag, "_steps"}, nstep_w, ds);
    chki({tag, "_sat_steps"}, nstep_s, dss);
  endtask

  initial begin
    int g_end, h_end, j_end, k_end, l_end;
    int s0, t0, first;

    // A: CW detent
    add(1,0,8'h00,0,0,8'h00,0); add(0,0,8'h00,0,0,8'h00,0);
    add(0,1,8'h00,0,0,8'h00,0); add(1,1,8'h01,1,1,8'h01,1);
    // B: CCW detent
    add(0,1,8'h01,1,0,8'h01,0); add(0,0,8'h01,1,0,8'h01,0);
    add(1,0,8'h01,1,0,8'h01,0); add(1,1,8'h00,0,1,8'h00,1);
    // C: CCW from zero: wrap vs saturate
    add(0,1,8'h00,0,0,8'h00,0); add(0,0,8'h00,0,0,8'h00,0);
    add(1,0,8'h00,0,0,8'h00,0); add(1,1,8'hFF,0,1,8'h00,0);
    // D: CW back across the wrap
    add(1,0,8'hFF,0,0,8'h00,0); add(0,0,8'hFF,0,0,8'h00,0);
    add(0,1,8'hFF,0,0,8'h00,0); add(1,1,8'h00,1,1,8'h01,1);
    // E: reversal mid-detent
    add(1,0,8'h00,1,0,8'h01,0); add(0,0,8'h00,1,0,8'h01,0);
    add(1,0,8'h00,1,0,8'h01,0); add(1,1,8'h00,1,0,8'h01,0);
    // F: invalid 00->11 clears a +2 accumulator
    add(1,0,8'h00,1,0,8'h01,0); add(0,0,8'h00,1,0,8'h01,0);
    add(1,1,8'h00,1,0,8'h01,0); add(1,0,8'h00,1,0,8'h01,0);
    add(0,0,8'h00,1,0,8'h01,0); add(0,1,8'h00,1,0,8'h01,0);
    add(1,1,8'h01,1,1,8'h02,1);
    // G: invalid 11->00, then a detent starting from 00, then invalid back
    add(0,0,8'h01,1,0,8'h02,0); add(0,1,8'h01,1,0,8'h02,0);
    add(1,1,8'h01,1,0,8'h02,0); add(1,0,8'h01,1,0,8'h02,0);
    add(0,0,8'h02,1,1,8'h03,1); add(1,1,8'h02,1,0,8'h03,0);
    g_end = tbl.size();
    // H: two CW detents (after latency test at 03/04)
    add(1,0,8'h03,1,0,8'h04,0); add(0,0,8'h03,1,0,8'h04,0);
    add(0,1,8'h03,1,0,8'h04,0); add(1,1,8'h04,1,1,8'h05,1);
    add(1,0,8'h04,1,0,8'h05,0); add(0,0,8'h04,1,0,8'h05,0);
    add(0,1,8'h04,1,0,8'h05,0); add(1,1,8'h05,1,1,8'h06,1);
    h_end = tbl.size();
    // I: CCW detent after clear; J: three CW transitions pending
    add(0,1,8'h00,1,0,8'h00,0); add(0,0,8'h00,1,0,8'h00,0);
    add(1,0,8'h00,1,0,8'h00,0); add(1,1,8'hFF,0,1,8'h00,0);
    add(1,0,8'hFF,0,0,8'h00,0); add(0,0,8'hFF,0,0,8'h00,0);
    add(0,1,8'hFF,0,0,8'h00,0);
    j_end = tbl.size();
    // K: CW detent, then 3/4 of another before reset
    add(1,0,8'h00,0,0,8'h00,0); add(0,0,8'h00,0,0,8'h00,0);
    add(0,1,8'h00,0,0,8'h00,0); add(1,1,8'h01,1,1,8'h01,1);
    add(1,0,8'h01,1,0,8'h01,0); add(0,0,8'h01,1,0,8'h01,0);
    add(0,1,8'h01,1,0,8'h01,0);
    k_end = tbl.size();
    // L: full detent after reset steps only on its last edge
    add(1,0,8'h00,0,0,8'h00,0); add(0,0,8'h00,0,0,8'h00,0);
    add(0,1,8'h00,0,0,8'h00,0); add(1,1,8'h01,1,1,8'h01,1);
    l_end = tbl.size();

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_count", ifw.o_count, 8'h00);
    chk("rst_hexhi", 8'(ifw.o_hexHigh), 8'h0);
    chk("rst_hexlo", 8'(ifw.o_hexLow), 8'h0);
    chk("rst_step", 8'(ifw.o_step), 8'h0);
    chk("rst_dir", 8'(ifw.o_dir), 8'h0);
    chk("rst_sat_count", ifs.o_count, 8'h00);
    rst = 1'b0;

    run_tbl(0, g_end);

    // Bounce on A never survives the filter
    s0 = nstep_w; t0 = nstep_s;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 a = ~a;
      @(posedge clk);
    end
    hold(1, 1, 20);
    chk_both("bounce", 8'h02, 8'h03, 1'b1, s0, t0);

    // Latency from final pin edge of a detent to the step pulse
    hold(1, 0, 10); hold(0, 0, 10); hold(0, 1, 10);
    s0 = nstep_w; t0 = nstep_s;
    first = -1;
    @(posedge clk); #1 a = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk); #1;
      if (first < 0 && ifw.o_step === 1'b1) first = i;
    end
    chki("latency_cycles", first, 7);
    @(negedge clk); #1;
    chk_both("latency", 8'h03, 8'h04, 1'b1, s0 + 1, t0 + 1);

    run_tbl(g_end, h_end);
    chk("preclr_hexhi", 8'(ifw.o_hexHigh), 8'h0);
    chk("preclr_hexlo", 8'(ifw.o_hexLow), 8'h5);

    // Held button clears once
    s0 = nstep_w; t0 = nstep_s;
    @(posedge clk); #1 btn = 1'b1;
    repeat (20) @(posedge clk);
    #1 btn = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk); #1;
    chk_both("btn", 8'h00, 8'h00, 1'b1, s0 + 1, t0 + 1);

    run_tbl(h_end, j_end);

    // Detent completes in the same cycle as the button edge: clear wins
    s0 = nstep_w; t0 = nstep_s;
    @(posedge clk); #1 a = 1'b1; b = 1'b1; btn = 1'b1;
    repeat (20) @(posedge clk);
    #1 btn = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk); #1;
    chk_both("clr_vs_step", 8'h00, 8'h00, 1'b0, s0 + 1, t0 + 1);

    run_tbl(j_end, k_end);

    // Reset mid-detent discards the accumulator and count
    s0 = nstep_w; t0 = nstep_s;
    @(posedge clk); #1 a = 1'b1; b = 1'b1; rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); #1;
    chk_both("mid_rst", 8'h00, 8'h00, 1'b0, s0, t0);

    run_tbl(k_end, l_end);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
